// File: rtl/mem_stall_ctrl.sv
// Memory-access stall controller: accepts a core load/store, waits a fixed latency, then acks.
// Latency: RD_LAT/WR_LAT busy cycles after acceptance, ack in the following cycle.
// Backpressure: ext_stall holds the completion (DONE) until it drops; stall freezes the core meanwhile.
module mem_stall_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        wsel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ext_stall,
  input  logic              cnt_clr,
  output logic              stall,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_w,
  output logic [2:0]        mem_w_sel,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Wait counter is 4 bits wide, so latencies must fit 1..15.
  generate
    if (RD_LAT < 1 || RD_LAT > 15 || WR_LAT < 1 || WR_LAT > 15) begin : g_bad_lat
      $error("mem_stall_ctrl: RD_LAT and WR_LAT must be within 1..15");
    end
  endgenerate

  localparam logic [3:0]       RD_L    = 4'(RD_LAT);
  localparam logic [3:0]       WR_L    = 4'(WR_LAT);
  localparam logic [3:0]       WAIT_1  = 4'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt;
  logic             lat_we;
  logic             accept;
  logic             last_busy;

  assign accept    = (state == IDLE) && req && !ext_stall;
  assign last_busy = (state == BUSY) && (wait_cnt == WAIT_1);

  // Next-state and handshake outputs; ext_stall never stretches BUSY, only DONE.
  always_comb begin
    state_nxt = state;
    stall     = ext_stall;
    ack       = 1'b0;
    mem_w     = 1'b0;
    case (state)
      IDLE: begin
        stall = ext_stall | req;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        mem_w = last_busy & lat_we;
        if (last_busy) state_nxt = DONE;
      end
      DONE: begin
        ack = !ext_stall;
        if (!ext_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latch, wait counter and read-data capture; latched fields hold through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_w_sel <= 3'd0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        wait_cnt  <= we ? WR_L : RD_L;
        lat_we    <= we;
        mem_addr  <= addr;
        mem_wdata <= wdata;
        mem_w_sel <= wsel;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt - WAIT_1;
      end
      if (last_busy && !lat_we) rdata <= mem_rdata;
    end
  end

  // Saturating stalled-cycle counter; clear takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_cnt <= '0;
    else if (cnt_clr)                  stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: directed scenarios plus random traffic against a timestamp-based model.
// Two instances share inputs; the second uses a 4-bit stall counter to exercise saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
module tb_mem_stall_ctrl;
  localparam int RDL = 2;
  localparam int WRL = 1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, ext_stall = 1'b0, cnt_clr = 1'b0;
  logic [2:0]  wsel = 3'd0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;

  logic        stall, ack, mem_w;
  logic [31:0] rdata, mem_addr, mem_wdata, stall_cnt;
  logic [2:0]  mem_w_sel;
  logic        stall4, ack4, mem_w4;
  logic [31:0] rdata4, mem_addr4, mem_wdata4;
  logic [2:0]  mem_w_sel4;
  logic [3:0]  stall_cnt4;

  mem_stall_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RDL), .WR_LAT(WRL), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wsel(wsel), .addr(addr), .wdata(wdata),
    .ext_stall(ext_stall), .cnt_clr(cnt_clr), .stall(stall), .ack(ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_w_sel(mem_w_sel),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt));

  mem_stall_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RDL), .WR_LAT(WRL), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wsel(wsel), .addr(addr), .wdata(wdata),
    .ext_stall(ext_stall), .cnt_clr(cnt_clr), .stall(stall4), .ack(ack4), .rdata(rdata4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_w(mem_w4), .mem_w_sel(mem_w_sel4),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt4));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: an access is a timestamp (cycle accepted) plus its latency.
  bit          m_active = 1'b0;
  int          m_acc    = 0;
  int          m_lat    = 0;
  bit          m_we     = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [2:0]  m_wsel = '0;
  logic [31:0] m_cnt  = '0;
  logic [3:0]  m_cnt4 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = idle, 1 = waiting on memory, 2 = completed and waiting to hand back.
  function automatic int phase();
    if (!m_active)           return 0;
    if (cyc - m_acc <= m_lat) return 1;
    return 2;
  endfunction

  task automatic step(input bit r, input bit w, input logic [2:0] ws, input logic [31:0] a,
                      input logic [31:0] wd, input bit ex, input bit cl, input logic [31:0] mrd);
    int ph;
    int k;
    bit e_stall;
    req = r; we = w; wsel = ws; addr = a; wdata = wd; ext_stall = ex; cnt_clr = cl; mem_rdata = mrd;
    #3;
    ph = phase();
    k  = cyc - m_acc;
    e_stall = ex | (ph == 0 && r) | (ph == 1);
    chk("stall",      64'(stall),      64'(e_stall));
    chk("ack",        64'(ack),        64'(ph == 2 && !ex));
    chk("mem_w",      64'(mem_w),      64'(ph == 1 && m_we && k == m_lat));
    chk("rdata",      64'(rdata),      64'(m_rdata));
    chk("mem_addr",   64'(mem_addr),   64'(m_addr));
    chk("mem_wdata",  64'(mem_wdata),  64'(m_wdata));
    chk("mem_w_sel",  64'(mem_w_sel),  64'(m_wsel));
    chk("stall_cnt",  64'(stall_cnt),  64'(m_cnt));
    chk("stall_cnt4", 64'(stall_cnt4), 64'(m_cnt4));
    @(posedge clk);
    if (cl) begin
      m_cnt  = '0;
      m_cnt4 = '0;
    end else if (e_stall) begin
      if (m_cnt  != 32'hFFFF_FFFF) m_cnt  = m_cnt + 32'd1;
      if (m_cnt4 != 4'hF)          m_cnt4 = m_cnt4 + 4'd1;
    end
    if (ph == 0 && r && !ex) begin
      m_active = 1'b1; m_acc = cyc; m_we = w; m_lat = w ? WRL : RDL;
      m_addr = a; m_wdata = wd; m_wsel = ws;
    end else if (ph == 1 && k == m_lat) begin
      if (!m_we) m_rdata = mrd;
    end else if (ph == 2 && !ex) begin
      m_active = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    req = 1'b0; ext_stall = 1'b0; cnt_clr = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_stall",     64'(stall),      64'(0));
    chk("rst_ack",       64'(ack),        64'(0));
    chk("rst_mem_w",     64'(mem_w),      64'(0));
    chk("rst_rdata",     64'(rdata),      64'(0));
    chk("rst_mem_addr",  64'(mem_addr),   64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata),  64'(0));
    chk("rst_mem_w_sel", 64'(mem_w_sel),  64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt),  64'(0));
    chk("rst_cnt4",      64'(stall_cnt4), 64'(0));
    m_active = 1'b0; m_addr = '0; m_wdata = '0; m_wsel = '0; m_rdata = '0;
    m_cnt = '0; m_cnt4 = '0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Read at 0x10, first request right after reset release.
    step(1, 0, 3'd2, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF);
    step(0, 0, 3'd0, 32'h0,  32'h0, 0, 0, 32'hDEADBEEF);
    step(0, 0, 3'd0, 32'h0,  32'h0, 0, 0, 32'hDEADBEEF);
    chk("r22_ack",   64'(ack),       64'(1));
    chk("r22_rdata", 64'(rdata),     64'(32'hDEADBEEF));
    chk("r22_cnt",   64'(stall_cnt), 64'(3));
    step(0, 0, 3'd0, 32'h0,  32'h0, 0, 0, 32'h0);

    // Single-cycle write.
    step(1, 1, 3'd2, 32'h20, 32'h12345678, 0, 0, 32'h0);
    chk("r23_mem_w",     64'(mem_w),     64'(1));
    chk("r23_mem_addr",  64'(mem_addr),  64'(32'h20));
    chk("r23_mem_wdata", 64'(mem_wdata), 64'(32'h12345678));
    chk("r23_mem_w_sel", 64'(mem_w_sel), 64'(2));
    step(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("r23_ack",       64'(ack),       64'(1));
    chk("r23_rdata",     64'(rdata),     64'(32'hDEADBEEF));
    step(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Read with ext_stall through BUSY and three cycles past it.
    step(1, 0, 3'd0, 32'h30, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < RDL + 3; i++) step(0, 0, 3'd0, 32'h0, 32'h0, 1, 0, 32'hCAFEF00D);
    chk("r24_rdata", 64'(rdata), 64'(32'hCAFEF00D));
    step(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Reset in the middle of a write's BUSY cycle, then a normal read.
    step(1, 1, 3'd1, 32'h44, 32'hA5A5A5A5, 0, 0, 32'h0);
    do_reset();
    step(1, 0, 3'd2, 32'h48, 32'h0, 0, 0, 32'h0BADF00D);
    for (int i = 0; i < RDL + 2; i++) step(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0BADF00D);
    chk("r25_rdata", 64'(rdata), 64'(32'h0BADF00D));

    // req held high: back-to-back reads.
    for (int i = 0; i < 2 * (RDL + 2) + 2; i++)
      step(1, 0, 3'd2, 32'h50 + 32'(i), 32'h0, 0, 0, $urandom);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), $urandom);

    // Continuous reads saturate the narrow counter; clear wins over a stalled cycle.
    for (int i = 0; i < 25; i++) step(1, 0, 3'd2, 32'h60, 32'h0, 0, 0, $urandom);
    chk("r26_sat", 64'(stall_cnt4), 64'(4'hF));
    step(1, 0, 3'd2, 32'h60, 32'h0, 1, 1, $urandom);
    chk("r26_clr4", 64'(stall_cnt4), 64'(0));
    chk("r26_clr",  64'(stall_cnt),  64'(0));
    for (int i = 0; i < 6; i++) step(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
